// File: rtl/sync_down_counter_6bit_pkg.sv
// Shared constants and the per-edge action type for the synchronous
// down counter built from JK flip-flops.
package sync_down_counter_6bit_pkg;

    localparam int COUNTER_WIDTH = 6;
    localparam int unsigned DEFAULT_RELOAD = 63;
    localparam logic [COUNTER_WIDTH-1:0] ZERO_COUNT = '0;

    // What the next rising edge does to the count.
    typedef enum logic [2:0] {
        MODE_HOLD,
        MODE_LOAD,
        MODE_DEC,
        MODE_WRAP,
        MODE_STOP
    } count_mode_t;

endpackage

// File: rtl/sync_down_counter_6bit_jkff_n.sv
// JK flip-flop with asynchronous active-low clear and complementary outputs.
// j/k: 00 hold, 01 reset, 10 set, 11 toggle.
module jkff_n (
    input  logic clk,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/sync_down_counter_6bit.sv
// Synchronous down counter: one JK flop per bit, borrow-lookahead toggles for
// decrement, J/K set/clear pairs for load, wrap-to-RELOAD and one-shot stop.
module sync_down_counter_6bit
    import sync_down_counter_6bit_pkg::*;
#(
    parameter int          WIDTH  = COUNTER_WIDTH,
    parameter int unsigned RELOAD = DEFAULT_RELOAD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO_Q   = WIDTH'(ZERO_COUNT);
    localparam logic [WIDTH-1:0] RELOAD_Q = WIDTH'(RELOAD);

    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             q_is_zero;
    count_mode_t      mode;

    assign q_is_zero = (q == ZERO_Q);
    assign zero      = q_is_zero;

    always_comb begin
        mode = MODE_HOLD;
        if (load) begin
            mode = MODE_LOAD;
        end else if (en) begin
            if (!q_is_zero) begin
                mode = MODE_DEC;
            end else if (one_shot) begin
                mode = MODE_STOP;
            end else begin
                mode = MODE_WRAP;
            end
        end
    end

    // Bit i toggles on a decrement only when every lower bit is already zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_toggle
            if (gi == 0) begin : g_lsb
                assign t[gi] = en;
            end else begin : g_upper
                assign t[gi] = en & (&qn[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        j = '0;
        k = '0;
        case (mode)
            MODE_LOAD: begin
                j = din;
                k = ~din;
            end
            MODE_DEC: begin
                j = t;
                k = t;
            end
            MODE_WRAP: begin
                j = RELOAD_Q;
                k = ~RELOAD_Q;
            end
            MODE_STOP: begin
                j = '0;
                k = '1;
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jkff_n u_jkff (
                .clk   (clk),
                .clr_n (reset),
                .j     (j[gi]),
                .k     (k[gi]),
                .q     (q[gi]),
                .qn    (qn[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (mode)
                MODE_LOAD: begin
                    borrow <= 1'b0;
                    done   <= one_shot && (din == ZERO_Q);
                end
                MODE_DEC: begin
                    borrow <= 1'b0;
                    done   <= 1'b0;
                end
                MODE_WRAP: begin
                    borrow <= 1'b1;
                    done   <= 1'b0;
                end
                MODE_STOP: begin
                    borrow <= 1'b0;
                    done   <= 1'b1;
                end
                default: begin
                    borrow <= 1'b0;
                    done   <= done;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_down_counter_6bit.sv
// Directed bench for sync_down_counter_6bit: default RELOAD plus RELOAD=9 and
// RELOAD=0 instances sharing the same stimulus.
module tb_sync_down_counter_6bit;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [5:0] din;
    logic       one_shot;

    logic [5:0] q_a, q_9, q_0;
    logic       zero_a, zero_9, zero_0;
    logic       borrow_a, borrow_9, borrow_0;
    logic       done_a, done_9, done_0;

    int total = 0;
    int bad   = 0;

    sync_down_counter_6bit dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .one_shot(one_shot), .q(q_a), .zero(zero_a), .borrow(borrow_a), .done(done_a)
    );

    sync_down_counter_6bit #(.RELOAD(9)) dut9 (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .one_shot(one_shot), .q(q_9), .zero(zero_9), .borrow(borrow_9), .done(done_9)
    );

    sync_down_counter_6bit #(.RELOAD(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .one_shot(one_shot), .q(q_0), .zero(zero_0), .borrow(borrow_0), .done(done_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] seq5 [7];
        logic [5:0] seq9 [11];
        seq5 = '{6'd4, 6'd3, 6'd2, 6'd1, 6'd0, 6'd63, 6'd62};
        seq9 = '{6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0, 6'd9};

        reset = 1'b1; en = 1'b0; load = 1'b0; din = '0; one_shot = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_q", q_a, 0);
        chk("rst_zero", zero_a, 1);
        chk("rst_borrow", borrow_a, 0);
        chk("rst_done", done_a, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_hold_q", q_a, 0);
            chk("rst_hold_zero", zero_a, 1);
        end
        reset = 1'b1;
        step();
        chk("rel_q", q_a, 0);
        chk("rel_zero", zero_a, 1);
        chk("rel_borrow", borrow_a, 0);
        chk("rel_done", done_a, 0);

        // wrap sequence 5..0 -> 63
        load = 1'b1; din = 6'd5; one_shot = 1'b0;
        step();
        chk("ld5_q", q_a, 5);
        chk("ld5_zero", zero_a, 0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("wrap_q", q_a, seq5[i]);
            chk("wrap_borrow", borrow_a, (seq5[i] == 6'd63) ? 1 : 0);
            chk("wrap_zero", zero_a, (seq5[i] == 6'd0) ? 1 : 0);
        end

        // one-shot stop at zero
        en = 1'b0; load = 1'b1; din = 6'd2; one_shot = 1'b1;
        step();
        chk("os_ld_q", q_a, 2);
        chk("os_ld_done", done_a, 0);
        load = 1'b0; en = 1'b1;
        step(); chk("os_q1", q_a, 1); chk("os_done1", done_a, 0);
        step(); chk("os_q0", q_a, 0); chk("os_done0", done_a, 0);
        step(); chk("os_stop_q", q_a, 0); chk("os_stop_done", done_a, 1);
        chk("os_stop_borrow", borrow_a, 0);
        step(); chk("os_stop2_q", q_a, 0); chk("os_stop2_done", done_a, 1);
        chk("os_stop2_borrow", borrow_a, 0);
        en = 1'b0;
        step(); chk("hold_done", done_a, 1); chk("hold_q", q_a, 0);
        load = 1'b1; din = 6'd0;
        step(); chk("ld0_os_done", done_a, 1);
        one_shot = 1'b0; din = 6'd3;
        step(); chk("ld3_done", done_a, 0); chk("ld3_q", q_a, 3);

        // load has priority over en
        din = 6'd40;
        step(); chk("ld40_q", q_a, 40);
        load = 1'b0; en = 1'b1;
        step(); chk("dec39_q", q_a, 39);
        load = 1'b1; din = 6'd12;
        step(); chk("ldpri_q", q_a, 12);
        load = 1'b0;
        step(); chk("dec11_q", q_a, 11);
        step(); chk("dec10_q", q_a, 10);

        // async reset mid-cycle
        en = 1'b0; load = 1'b1; din = 6'd17;
        step(); chk("ld17_q", q_a, 17);
        load = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("arst_q", q_a, 0);
        chk("arst_zero", zero_a, 1);
        chk("arst_borrow", borrow_a, 0);
        #1 reset = 1'b1;
        en = 1'b1; one_shot = 1'b0;
        step(); chk("post_rst_q", q_a, 63); chk("post_rst_borrow", borrow_a, 1);
        #3 reset = 1'b0;
        #1;
        chk("arst2_q", q_a, 0);
        chk("arst2_borrow", borrow_a, 0);
        #1 reset = 1'b1;
        en = 1'b0;
        step(); chk("arst2_hold_q", q_a, 0);

        // RELOAD=9 and RELOAD=0 instances
        load = 1'b1; din = 6'd0; one_shot = 1'b0;
        step();
        chk("r9_ld_q", q_9, 0);
        chk("r0_ld_q", q_0, 0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("r9_q", q_9, seq9[i]);
            chk("r9_borrow", borrow_9, (seq9[i] == 6'd9) ? 1 : 0);
            chk("r0_q", q_0, 0);
            chk("r0_borrow", borrow_0, 1);
        end
        en = 1'b0;
        step(); chk("r0_borrow_off", borrow_0, 0);

        // din above RELOAD counts down, next wrap goes to RELOAD
        load = 1'b1; din = 6'd11;
        step(); chk("r9_ld11_q", q_9, 11);
        load = 1'b0; en = 1'b1;
        step(); chk("r9_dec10_q", q_9, 10);
        load = 1'b1; din = 6'd0;
        step();
        load = 1'b0;
        step(); chk("r9_rewrap_q", q_9, 9); chk("r9_rewrap_borrow", borrow_9, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
